// File: rtl/sump_word_transmitter.sv
// Host TX path: serialises 32-bit words from the core as 8N1 UART frames, LSB byte first,
// skipping bytes whose channel group is disabled.
module sump_word_transmitter #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dataIn,
    input  logic        send,
    input  logic [3:0]  groupDisable,
    output logic        busy,
    output logic        txd
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [31:0]      word_q, word_d;
    logic [3:0]       mask_q, mask_d;
    logic             busy_q, busy_d;
    logic             txd_q, txd_d;

    logic [3:0]  sel_mask;
    logic [31:0] sel_word;
    logic [1:0]  sel_idx;
    logic [7:0]  sel_byte;
    logic [3:0]  rest_mask;
    logic        cnt_end;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // In IDLE the byte is picked straight from the request; later bytes come from the latched word.
    always_comb begin
        sel_mask  = (state_q == IDLE) ? ~groupDisable : mask_q;
        sel_word  = (state_q == IDLE) ? dataIn : word_q;
        sel_idx   = lowest_set(sel_mask);
        sel_byte  = sel_word[{sel_idx, 3'b000} +: 8];
        rest_mask = sel_mask & ~(4'b0001 << sel_idx);
        cnt_end   = (cnt_q == CNT_MAX);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        word_d  = word_q;
        mask_d  = mask_q;
        busy_d  = busy_q;
        txd_d   = txd_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                txd_d  = 1'b1;
                // busy_q high here means a fully-masked word was just taken; hold off one cycle.
                if (send && !busy_q) begin
                    word_d = dataIn;
                    mask_d = ~groupDisable;
                    busy_d = 1'b1;
                    if (sel_mask != 4'b0000) begin
                        shift_d = sel_byte;
                        mask_d  = rest_mask;
                        state_d = START;
                        txd_d   = 1'b0;
                    end
                end
            end
            START: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (mask_q != 4'b0000) begin
                        shift_d = sel_byte;
                        mask_d  = rest_mask;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            word_q  <= 32'h0;
            mask_q  <= 4'b0000;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
        end
    end

    assign busy = busy_q;
    assign txd  = txd_q;

endmodule

// File: tb/tb_sump_word_transmitter.sv
// Scoreboard bench for sump_word_transmitter: expected bytes queued at send, a UART monitor
// decodes txd cycle by cycle and compares framing, byte values and busy duration.
module tb_sump_word_transmitter;

    localparam int unsigned BAUD_DIV = 4;
    localparam int unsigned FRAME    = 10 * BAUD_DIV;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] dataIn;
    logic        send;
    logic [3:0]  groupDisable;
    logic        busy;
    logic        txd;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int frames_seen = 0;

    sump_word_transmitter #(.BAUD_DIV(BAUD_DIV)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .dataIn       (dataIn),
        .send         (send),
        .groupDisable (groupDisable),
        .busy         (busy),
        .txd          (txd)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART monitor: one sample per cycle, whole frame checked once complete
    logic             mon_active = 1'b0;
    int               mon_cnt    = 0;
    logic [FRAME-1:0] mon_s;

    task automatic frame_done();
        logic [7:0]          b;
        logic                ok;
        logic [BAUD_DIV-1:0] w;
        ok = (mon_s[BAUD_DIV-1:0] == '0) && (mon_s[FRAME-1 -: BAUD_DIV] == '1);
        for (int i = 0; i < 8; i++) begin
            w    = mon_s[BAUD_DIV*(i+1) +: BAUD_DIV];
            ok   = ok && ((w == '0) || (w == '1));
            b[i] = w[0];
        end
        frames_seen++;
        check("frame_timing", 32'(ok), 32'd1);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got 0x%0h expected no frame", b);
        end else begin
            check("byte", 32'(b), 32'(exp_q.pop_front()));
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            mon_active = 1'b0;
            mon_cnt    = 0;
        end else if (!mon_active) begin
            if (txd === 1'b0) begin
                mon_active = 1'b1;
                mon_s[0]   = 1'b0;
                mon_cnt    = 1;
            end
        end else begin
            mon_s[mon_cnt] = txd;
            mon_cnt++;
            if (mon_cnt == FRAME) begin
                mon_active = 1'b0;
                frame_done();
            end
        end
    end

    // busy run-length tracker
    int busy_run    = 0;
    int busy_len    = 0;
    int busy_events = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            busy_run = 0;
        end else if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
            busy_events++;
        end
    end

    task automatic push_bytes(input logic [31:0] data, input logic [3:0] gd);
        for (int i = 0; i < 4; i++)
            if (!gd[i]) exp_q.push_back(data[8*i +: 8]);
    endtask

    // called at #1 after a posedge; request is taken on the next edge, inputs scrambled after
    task automatic send_word(input logic [31:0] data, input logic [3:0] gd);
        push_bytes(data, gd);
        dataIn       = data;
        groupDisable = gd;
        send         = 1'b1;
        @(posedge clock); #1;
        send         = 1'b0;
        dataIn       = ~data;
        groupDisable = ~gd;
    endtask

    task automatic wait_idle(input int exp_len, input string name);
        int start;
        int t;
        start = busy_events;
        t     = 0;
        while (busy_events == start && t < 5000) begin
            @(negedge clock); #1;
            t++;
        end
        if (busy_events == start) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: busy never dropped, expected %0d cycles", name, exp_len);
        end else begin
            check(name, 32'(busy_len), 32'(exp_len));
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int base;
        int t;
        reset_n      = 1'b0;
        send         = 1'b0;
        dataIn       = 32'h0;
        groupDisable = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // all four bytes
        send_word(32'h44332211, 4'b0000);
        wait_idle(4 * FRAME, "busy_4bytes");

        // groups 1 and 3 disabled
        send_word(32'h44332211, 4'b1010);
        wait_idle(2 * FRAME, "busy_2bytes");

        // everything disabled, then an immediate follow-up request
        send_word(32'hCAFEF00D, 4'b1111);
        wait_idle(1, "busy_masked");
        send_word(32'h000000C3, 4'b1110);
        wait_idle(FRAME, "busy_after_masked");

        // 0x55 bit pattern followed back-to-back by 0x00
        send_word(32'h00000055, 4'b1100);
        wait_idle(2 * FRAME, "busy_back_to_back");

        // send held 3 cycles plus a stray pulse mid-word
        push_bytes(32'h0D0C0B0A, 4'b0000);
        dataIn       = 32'h0D0C0B0A;
        groupDisable = 4'b0000;
        send         = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        send   = 1'b0;
        dataIn = 32'h12345678;
        repeat (50) @(posedge clock);
        #1;
        send   = 1'b1;
        dataIn = 32'hDEADBEEF;
        @(posedge clock); #1;
        send = 1'b0;
        wait_idle(4 * FRAME, "busy_dropped_sends");

        // reset in the middle of the second byte
        base = frames_seen;
        send_word(32'h88776655, 4'b0000);
        t = 0;
        while (frames_seen == base && t < 1000) begin
            @(negedge clock);
            t++;
        end
        check("first_frame_before_reset", 32'(frames_seen), 32'(base + 1));
        repeat (10) @(posedge clock);
        #1;
        check("busy_mid_byte2", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_txd", 32'(txd), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        exp_q.delete();
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("post_reset_txd", 32'(txd), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        send_word(32'h000000A5, 4'b1110);
        wait_idle(FRAME, "busy_after_reset");

        repeat (10) @(posedge clock);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_txd", 32'(txd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
